// File: rtl/panel_programmer.sv
// rtl/panel_programmer.sv - front-panel RAM programmer with synchronised, debounced controls
//
// pp_debounce: 2-flop synchroniser followed by a stable-count debouncer.
//   clk, rst      : system clock, synchronous active-high reset
//   din           : raw asynchronous input
//   level_q       : registered debounced level
//   level_d       : next debounced level (value level_q takes at the coming edge)
//
// panel_programmer: halts the CPU and lets an operator load an address and
// write switch data into RAM through push buttons.
//   clk, rst                 : system clock, synchronous active-high reset
//   prog_mode                : raw switch, 1 requests program mode
//   load_addr_btn, write_btn : raw push buttons
//   auto_inc                 : post-increment address after each write
//   addr_sw, data_sw         : address / data switches
//   ram_addr, ram_wdata      : registered RAM address and write data
//   ram_we                   : single-cycle write strobe
//   cpu_hold                 : 1 while the panel owns the RAM
//   wrap_flag                : sticky, auto-increment wrapped to zero

module pp_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level_q,
    output logic level_d
);
    localparam int CW = $clog2(CYCLES);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            // Flip on the CYCLES-th consecutive differing sample.
            if (cnt_q == CW'(CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
endmodule

module panel_programmer #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  load_addr_btn,
    input  logic                  write_btn,
    input  logic                  auto_inc,
    input  logic [ADDR_WIDTH-1:0] addr_sw,
    input  logic [DATA_WIDTH-1:0] data_sw,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  cpu_hold,
    output logic                  wrap_flag
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_READY = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wrap_q, wrap_d;

    logic prog_lvl_q, prog_lvl_d;
    logic load_lvl_q, load_lvl_d;
    logic wr_lvl_q, wr_lvl_d;
    logic load_ev, write_ev;

    pp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prog (
        .clk(clk), .rst(rst), .din(prog_mode),
        .level_q(prog_lvl_q), .level_d(prog_lvl_d)
    );
    pp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst(rst), .din(load_addr_btn),
        .level_q(load_lvl_q), .level_d(load_lvl_d)
    );
    pp_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_write (
        .clk(clk), .rst(rst), .din(write_btn),
        .level_q(wr_lvl_q), .level_d(wr_lvl_d)
    );

    // The FSM acts on the debounced value being committed at this edge, so a
    // state change lands on the same edge the debounced level changes.
    assign load_ev  = load_lvl_d & ~load_lvl_q;
    assign write_ev = wr_lvl_d & ~wr_lvl_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wrap_d  = wrap_q;
        case (state_q)
            ST_RUN: begin
                if (prog_lvl_d) begin
                    state_d = ST_HOLD;
                    wrap_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                // Leaving program mode wins; any same-cycle event is dropped.
                if (!prog_lvl_d) begin
                    state_d = ST_RUN;
                end else if (write_ev) begin
                    if (load_ev) begin
                        addr_d = addr_sw;
                    end
                    wdata_d = data_sw;
                    state_d = ST_WRITE;
                end else if (load_ev) begin
                    addr_d = addr_sw;
                end
            end
            ST_WRITE: begin
                state_d = ST_READY;
                if (auto_inc) begin
                    addr_d = addr_q + 1'b1;
                    if (&addr_q) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            wdata_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign wrap_flag = wrap_q;
    assign ram_we    = (state_q == ST_WRITE);
    assign cpu_hold  = (state_q != ST_RUN);
endmodule

// File: doc/panel_programmer.md
PANEL_PROGRAMMER -- requirements
Module: panel_programmer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width in bits.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, stable-cycle count for debounce; legal range >=2.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prog_mode  input  1  raw slide switch; 1 = program mode requested.
REQ-007 load_addr_btn  input  1  raw push button; press loads address from addr_sw.
REQ-008 write_btn  input  1  raw push button; press writes data_sw to RAM.
REQ-009 auto_inc  input  1  level; 1 = post-increment address after each write.
REQ-010 addr_sw  input  ADDR_WIDTH  address switches; sampled only on a load event.
REQ-011 data_sw  input  DATA_WIDTH  data switches; sampled only on a write event.
REQ-012 ram_addr  output  ADDR_WIDTH  current programming address.
REQ-013 ram_wdata  output  DATA_WIDTH  write data presented to RAM.
REQ-014 ram_we  output  1  single-cycle RAM write strobe.
REQ-015 cpu_hold  output  1  1 = CPU clock must halt; panel owns RAM.
REQ-016 wrap_flag  output  1  sticky; 1 = auto-increment wrapped from all-ones to zero.

Function
REQ-017 prog_mode, load_addr_btn and write_btn SHALL each pass through a 2-flop synchroniser, then a debouncer.
REQ-018 Debouncer SHALL update its level only after synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality clears its counter.
REQ-019 Stable raw change SHALL reach debounced level exactly DEBOUNCE_CYCLES+2 rising edges after first sampling edge.
REQ-020 Button event SHALL be a single-cycle pulse on 0->1 debounced transition; release generates no event.
REQ-021 FSM states SHALL be RUN, HOLD, READY, WRITE.
REQ-022 RUN: cpu_hold=0; debounced prog_mode=1 -> HOLD; button events ignored.
REQ-023 HOLD: cpu_hold=1, wrap_flag cleared; unconditional -> READY next cycle (CPU settle cycle).
REQ-024 READY, debounced prog_mode=0 -> RUN; exit has priority over any same-cycle event, which is dropped.
REQ-025 READY, load event only: ram_addr <= addr_sw; stay READY.
REQ-026 READY, write event only: ram_wdata <= data_sw; -> WRITE.
REQ-027 READY, load and write events same cycle: ram_addr <= addr_sw and ram_wdata <= data_sw; -> WRITE (write lands at new address).
REQ-028 WRITE: ram_we=1 for exactly this one cycle with registered ram_addr/ram_wdata stable; -> READY next cycle.
REQ-029 Leaving WRITE with auto_inc=1: ram_addr <= (ram_addr+1) mod 2^ADDR_WIDTH; if ram_addr was all-ones, wrap_flag <= 1.
REQ-030 Leaving WRITE with auto_inc=0: ram_addr unchanged.
REQ-031 Events arriving while in WRITE or HOLD SHALL be dropped, not queued.
REQ-032 cpu_hold SHALL be 1 in HOLD, READY, WRITE; 0 in RUN; ram_we SHALL be 0 outside WRITE.
REQ-033 ram_addr, ram_wdata, wrap_flag SHALL retain values across RUN (except wrap_flag clear in HOLD).

Reset
REQ-034 rst=1 at a rising edge SHALL set state RUN, ram_addr=0, ram_wdata=0, ram_we=0, cpu_hold=0, wrap_flag=0, all synchroniser flops, debounced levels and counters 0.
REQ-035 rst during WRITE SHALL deassert ram_we at that edge; no partial or repeated write.
REQ-036 prog_mode held high through reset release SHALL enter HOLD DEBOUNCE_CYCLES+2 edges after release, per REQ-019.

Verification (DEBOUNCE_CYCLES=4, ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-037 Reset, all inputs 0 -> all outputs 0, state RUN, held 20 cycles.
REQ-038 prog_mode=1 stable -> cpu_hold=1 at edge 6, READY at edge 7; addr_sw=0xA load press -> ram_addr=0xA; data_sw=0x3C, auto_inc=1, write press -> one ram_we cycle with addr 0xA data 0x3C, then ram_addr=0xB.
REQ-039 write_btn toggling every 2 cycles for 12 cycles then low -> no ram_we, ram_addr unchanged.
REQ-040 ram_addr=0xF, auto_inc=1, write -> ram_addr=0x0, wrap_flag=1; flag holds through RUN, clears on next HOLD.
REQ-041 addr_sw=0x5, data_sw=0x81, load and write raw presses same cycle -> single ram_we at addr 0x5 data 0x81.
REQ-042 rst asserted in WRITE cycle -> ram_we=0, cpu_hold=0, ram_addr=0 after that edge; prog_mode dropped in READY with write press same cycle -> RUN, no ram_we.
